obi_spi_master: RTL and testbench
=================================

// Module: obi_spi_master
// PURPOSE
//  OBI target that turns bus accesses into SPI mode-0, MSB-first transfers. Sits directly downstream of obi_slave.
//  Has a 4-word register map (TX, RX, STATUS, CLKDIV) and one SPI shift engine with chip select, clock divider and loopback-free RX capture.
// PARAMETERS
//  ADDR_WIDTH   32       OBI address width
//  DATA_WIDTH   32       OBI data width
//  XFER_BITS    8        bits per SPI transfer, 1..DATA_WIDTH
//  DIV_DEFAULT  8'd4     reset value of CLKDIV
//  BASE_ADDR    32'h0    base of the 16-byte register window
// PORTS
//  clk_i         in   1             clock
//  rstn_i        in   1             reset; asynchronous, active-low
//  obi_req_i     in   1             request
//  obi_gnt_o     out  1             grant, combinational from req/addr/we/busy
//  obi_addr_i    in   ADDR_WIDTH    byte address
//  obi_we_i      in   1             1 = write
//  obi_be_i      in   DATA_WIDTH/8  byte enables; ignored, full-word access only
//  obi_wdata_i   in   DATA_WIDTH    write data
//  obi_rvalid_o  out  1             response valid
//  obi_rdata_o   out  DATA_WIDTH    read data; 0 for writes and unmapped reads
//  spi_sclk_o    out  1             SPI clock, idles low
//  spi_cs_no     out  1             chip select, active low
//  spi_mosi_o    out  1             master out
//  spi_miso_i    in   1             master in
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, rdata=0, sclk=0, cs_n=1, mosi=0, CLKDIV=DIV_DEFAULT, RX=0, rx_valid=0, state IDLE.
//   Async reset mid-transfer aborts immediately; cs_n goes high with no extra edge.
//  Map, offset = addr - BASE_ADDR:
//   0x0 TX W: low XFER_BITS start a transfer. Read returns 0.
//   0x4 RX R: last received word, zero-extended. Read clears rx_valid.
//   0x8 STATUS R: bit0 busy, bit1 rx_valid.
//   0xC CLKDIV RW: bits[7:0].
//   Outside the window: granted; writes are dropped and reads return 0.
//  OBI:
//   gnt = req, except it is held low while busy for writes to TX or CLKDIV (stall, no drop).
//   rvalid is asserted exactly 1 cycle after each granted req, and rdata is valid in that same cycle.
//   Back-to-back requests are granted in consecutive cycles, so rvalid can stay high continuously.
//  Timing: half-period H = CLKDIV+1 clk cycles, counted by an 8-bit down-counter.
//  FSM:
//   IDLE: a TX write is granted -> load shift reg, cs_n=0, mosi=MSB (bit XFER_BITS-1) -> SETUP.
//   SETUP: wait H -> HIGH.
//   HIGH: sclk=1; sample miso into LSB on entry; wait H -> LOW.
//   LOW: sclk=0; shift; mosi = next bit; wait H.
//    If more bits remain -> HIGH.
//    After the last bit -> IDLE, with cs_n=1, RX<=shift reg and rx_valid=1, all in the same cycle.
//   cs_n is low for (2*XFER_BITS+1)*H cycles.
//   busy=1 in every state except IDLE and drops in the same cycle that cs_n rises.
//  Simultaneous events:
//   An RX read granted in the completion cycle returns the old RX, and rx_valid stays 1 (set wins).
//   A TX write presented in the completion cycle is stalled by 1 cycle, because busy is still 1 that cycle.
//  Reads are never stalled.
// TESTING
//  1. Reset release with idle bus -> cs_n=1, sclk=0, STATUS read = 0, CLKDIV read = 4.
//  2. CLKDIV=0, miso tied to mosi, write TX=0xA5 -> exactly 8 sclk rising edges,
//     cs_n low for 17 cycles, RX read = 0x000000A5, then STATUS = 0.
//  3. CLKDIV=2, miso driven 0x3C MSB-first -> sclk high/low phases 3 cycles each; RX = 0x3C; STATUS bit1 clears after the RX read.
//  4. Second TX write while busy -> gnt stays low until the cycle after busy falls;
//     the second transfer starts with no bit lost, and no rvalid is issued before gnt.
//  5. Back-to-back reads of STATUS, RX and 0x20 (unmapped) -> 3 consecutive gnt,
//     3 consecutive rvalid; the 0x20 read returns 0.
//  6. Assert rstn_i at bit 4 of a transfer -> cs_n=1, sclk=0 asynchronously;
//     after release, RX=0 and a new TX=0xFF completes normally.

Source files
------------

// File: rtl/obi_spi_master.sv
// ---------------------------------------------------------------------------
// obi_spi_master
// OBI target that turns register writes into SPI mode-0, MSB-first transfers.
// Four-word register window at BASE_ADDR:
//   0x0 TX     (W)  low XFER_BITS start a transfer; reads return 0
//   0x4 RX     (R)  last received word, zero-extended; reading clears rx_valid
//   0x8 STATUS (R)  bit0 busy, bit1 rx_valid
//   0xC CLKDIV (RW) bits[7:0], SPI half-period = CLKDIV+1 clk cycles
// Addresses outside the window are granted; writes are dropped, reads give 0.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   obi_req_i / obi_gnt_o  request / grant (grant stalls TX/CLKDIV writes
//                          while a transfer is running)
//   obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i   request payload
//   obi_rvalid_o, obi_rdata_o                     response, 1 cycle after grant
//   spi_sclk_o, spi_cs_no, spi_mosi_o, spi_miso_i SPI master pins
// ---------------------------------------------------------------------------
module obi_spi_master #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           XFER_BITS   = 8,
    parameter logic [7:0]            DIV_DEFAULT = 8'd4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    spi_sclk_o,
    output logic                    spi_cs_no,
    output logic                    spi_mosi_o,
    input  logic                    spi_miso_i
);

    localparam int unsigned BCW = $clog2(XFER_BITS + 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t                  state_reg, state_next;
    logic [7:0]              cnt_reg;
    logic [7:0]              clkdiv_reg;
    logic [BCW-1:0]          bits_left_reg;
    logic [XFER_BITS-1:0]    tx_sh_reg;
    logic [XFER_BITS-1:0]    rx_sh_reg;
    logic [XFER_BITS-1:0]    rx_reg;
    logic                    rx_valid_reg;
    logic                    sclk_reg;
    logic                    cs_n_reg;
    logic                    mosi_reg;
    logic                    rvalid_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;

    logic [ADDR_WIDTH-1:0]   offset;
    logic                    in_win;
    logic [3:0]              sel;       // one-hot register select: TX, RX, STATUS, CLKDIV
    logic                    busy;
    logic                    gnt;
    logic                    tx_start;
    logic                    tick;
    logic                    done;
    logic [XFER_BITS-1:0]    tx_shifted;
    logic                    unused_bits;

    // ---------------- address decode ----------------
    assign offset = obi_addr_i - BASE_ADDR;
    assign in_win = (offset[ADDR_WIDTH-1:4] == '0);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign sel[gi] = in_win && (offset[3:2] == 2'(gi));
        end
    endgenerate

    // ---------------- OBI handshake ----------------
    assign busy = (state_reg != IDLE);
    // Writes that would disturb a running transfer are stalled, never dropped.
    assign gnt      = obi_req_i && !(busy && obi_we_i && (sel[0] || sel[3]));
    assign tx_start = gnt && obi_we_i && sel[0];

    always_comb begin
        rdata_next = '0;
        if (gnt && !obi_we_i) begin
            if (sel[1]) begin
                rdata_next = DATA_WIDTH'(rx_reg);
            end else if (sel[2]) begin
                rdata_next[1:0] = {rx_valid_reg, busy};
            end else if (sel[3]) begin
                rdata_next[7:0] = clkdiv_reg;
            end
        end
    end

    // ---------------- SPI FSM ----------------
    assign tick       = (cnt_reg == 8'd0);
    assign done       = (state_reg == LOW) && tick && (bits_left_reg == '0);
    assign tx_shifted = tx_sh_reg << 1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (tx_start) state_next = SETUP;
            SETUP: if (tick)     state_next = HIGH;
            HIGH:  if (tick)     state_next = LOW;
            LOW:   if (tick)     state_next = (bits_left_reg == '0) ? IDLE : HIGH;
            default:             state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_reg       <= '0;
            clkdiv_reg    <= DIV_DEFAULT;
            bits_left_reg <= '0;
            tx_sh_reg     <= '0;
            rx_sh_reg     <= '0;
            rx_reg        <= '0;
            rx_valid_reg  <= 1'b0;
            sclk_reg      <= 1'b0;
            cs_n_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
            rvalid_reg    <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            rvalid_reg <= gnt;
            rdata_reg  <= rdata_next;

            // CLKDIV writes only get granted while idle, so the divider is
            // stable for the whole transfer.
            if (gnt && obi_we_i && sel[3]) begin
                clkdiv_reg <= obi_wdata_i[7:0];
            end

            // Every state lasts CLKDIV+1 cycles: reload on each transition.
            if (state_next != state_reg) begin
                cnt_reg <= clkdiv_reg;
            end else if (!tick) begin
                cnt_reg <= cnt_reg - 8'd1;
            end

            if (tx_start) begin
                tx_sh_reg     <= obi_wdata_i[XFER_BITS-1:0];
                mosi_reg      <= obi_wdata_i[XFER_BITS-1];
                bits_left_reg <= BCW'(XFER_BITS);
            end

            // Rising sclk: capture MISO into the separate RX shifter so the
            // TX bits still waiting to go out are not overwritten.
            if ((state_reg != HIGH) && (state_next == HIGH)) begin
                rx_sh_reg <= XFER_BITS'({rx_sh_reg, spi_miso_i});
            end

            // Falling sclk: present the next TX bit.
            if ((state_reg == HIGH) && tick) begin
                tx_sh_reg     <= tx_shifted;
                mosi_reg      <= tx_shifted[XFER_BITS-1];
                bits_left_reg <= bits_left_reg - BCW'(1);
            end

            // Completion sets rx_valid even if an RX read clears it in the
            // same cycle; that read still sees the previous RX word.
            if (done) begin
                rx_reg       <= rx_sh_reg;
                rx_valid_reg <= 1'b1;
            end else if (gnt && !obi_we_i && sel[1]) begin
                rx_valid_reg <= 1'b0;
            end

            sclk_reg <= (state_next == HIGH);
            cs_n_reg <= (state_next == IDLE);
        end
    end

    assign unused_bits = ^{obi_be_i, obi_wdata_i, offset[1:0]};

    assign obi_gnt_o    = gnt;
    assign obi_rvalid_o = rvalid_reg;
    assign obi_rdata_o  = rdata_reg;
    assign spi_sclk_o   = sclk_reg;
    assign spi_cs_no    = cs_n_reg;
    assign spi_mosi_o   = mosi_reg;

endmodule

// File: tb/tb_obi_spi_master.sv
// ---------------------------------------------------------------------------
// tb_obi_spi_master
// Directed plus randomized bench for obi_spi_master (8-bit transfers).
// A bus-level SPI slave model drives MISO (pattern or loopback) and measures
// each transfer: sclk edges, phase lengths, chip-select time and the bits
// seen on MOSI. Expectations come from the register-map and timing rules.
// ---------------------------------------------------------------------------
module tb_obi_spi_master;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = '0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = 4'hF;
    logic [31:0] obi_wdata_i = '0;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        spi_sclk_o;
    logic        spi_cs_no;
    logic        spi_mosi_o;
    logic        spi_miso_i;

    always #5 clk = ~clk;

    obi_spi_master dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .spi_sclk_o   (spi_sclk_o),
        .spi_cs_no    (spi_cs_no),
        .spi_mosi_o   (spi_mosi_o),
        .spi_miso_i   (spi_miso_i)
    );

    int tests = 0;
    int fails = 0;
    int early_rv = 0;

    // ---------------- SPI slave model ----------------
    logic        loop_en = 1'b0;
    logic [31:0] pat = '0;
    logic        miso_q = 1'b0;
    assign spi_miso_i = loop_en ? spi_mosi_o : miso_q;

    int          rises = 0, cs_low = 0, run = 0;
    int          hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
    logic [31:0] cap = '0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;

    task automatic rec_run(input logic lvl, input int len);
        if (lvl) begin
            if (len < hi_min) hi_min = len;
            if (len > hi_max) hi_max = len;
        end else begin
            if (len < lo_min) lo_min = len;
            if (len > lo_max) lo_max = len;
        end
    endtask

    always @(negedge clk) begin
        if (spi_cs_no === 1'b0) begin
            if (prev_cs) begin
                rises = 0; cs_low = 0; cap = '0; run = 0;
                hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0;
                miso_q = pat[7];
            end else if (spi_sclk_o !== prev_sclk) begin
                rec_run(prev_sclk, run);
                run = 0;
            end
            run++;
            cs_low++;
            if (spi_sclk_o && !prev_sclk) begin
                rises++;
                cap = {cap[30:0], spi_mosi_o};
            end
            // Mode-0 slave changes MISO after the falling edge.
            if (!spi_sclk_o && prev_sclk && rises < 8) miso_q = pat[7 - rises];
        end else if (!prev_cs) begin
            rec_run(prev_sclk, run);
        end
        prev_cs   = spi_cs_no;
        prev_sclk = spi_sclk_o;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single OBI access; call at posedge+1, returns at posedge+1.
    task automatic obi(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output int stall, output logic cs_at_gnt);
        logic got;
        got = 1'b0; stall = 0; rdata = '0; cs_at_gnt = 1'bx;
        obi_req_i = 1'b1; obi_we_i = we; obi_addr_i = addr; obi_wdata_i = wdata;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (obi_gnt_o === 1'b1) begin
                got = 1'b1;
                cs_at_gnt = spi_cs_no;
            end else begin
                stall++;
                if (obi_rvalid_o !== 1'b0) early_rv++;
            end
        end
        if (!got) check({tag, "_gnt_timeout"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        obi_req_i = 1'b0; obi_we_i = 1'b0;
        @(negedge clk);
        check({tag, "_rvalid"}, 32'(obi_rvalid_o), 32'd1);
        rdata = obi_rdata_o;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spi_cs_no !== 1'b1 && n < 5000);
        if (n >= 5000) check({tag, "_done_timeout"}, 32'(spi_cs_no), 32'd1);
        @(posedge clk); #1;
    endtask

    // Full transfer at a given divider, checked against the timing rules.
    task automatic run_xfer(input string tag, input int div, input logic [31:0] tx,
                            input logic lp, input logic [31:0] p);
        logic [31:0] rd;
        int          st, h;
        logic        cg;
        logic [7:0]  exp_rx;
        h = div + 1;
        loop_en = lp; pat = p;
        exp_rx = lp ? tx[7:0] : p[7:0];
        obi(tag, 1'b1, 32'hC, 32'(div), rd, st, cg);
        obi(tag, 1'b0, 32'hC, 32'h0, rd, st, cg);
        check({tag, "_clkdiv"}, rd, 32'(div));
        obi(tag, 1'b1, 32'h0, tx, rd, st, cg);
        wait_done(tag);
        check({tag, "_rises"}, 32'(rises), 32'd8);
        check({tag, "_cs_low"}, 32'(cs_low), 32'((2 * 8 + 1) * h));
        check({tag, "_hi_min"}, 32'(hi_min), 32'(h));
        check({tag, "_hi_max"}, 32'(hi_max), 32'(h));
        check({tag, "_lo_min"}, 32'(lo_min), 32'(h));
        check({tag, "_lo_max"}, 32'(lo_max), 32'(h));
        check({tag, "_mosi"}, cap, {24'h0, tx[7:0]});
        obi(tag, 1'b0, 32'h8, 32'h0, rd, st, cg);
        check({tag, "_status_rxv"}, rd, 32'h2);
        obi(tag, 1'b0, 32'h4, 32'h0, rd, st, cg);
        check({tag, "_rx"}, rd, {24'h0, exp_rx});
        obi(tag, 1'b0, 32'h8, 32'h0, rd, st, cg);
        check({tag, "_status_clr"}, rd, 32'h0);
        $display("[TB] xfer %s div=%0d tx=0x%02h loop=%0d rx_exp=0x%02h", tag, div, tx[7:0], lp, exp_rx);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, b;
        int          st, n;
        logic        cg;

        // ---- 1. reset state ----
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(obi_gnt_o), 32'd0);
        check("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
        check("rst_rdata", obi_rdata_o, 32'd0);
        check("rst_cs_n", 32'(spi_cs_no), 32'd1);
        check("rst_sclk", 32'(spi_sclk_o), 32'd0);
        check("rst_mosi", 32'(spi_mosi_o), 32'd0);
        #2 rstn_i = 1'b1;
        @(posedge clk); #1;
        obi("t1", 1'b0, 32'h8, 32'h0, rd, st, cg);
        check("t1_status", rd, 32'h0);
        obi("t1", 1'b0, 32'hC, 32'h0, rd, st, cg);
        check("t1_clkdiv", rd, 32'h4);
        $display("[TB] t1 reset state checked");

        // ---- 2. loopback, fastest clock ----
        run_xfer("t2", 0, 32'h0000_00A5, 1'b1, 32'h0);
        obi("t2b", 1'b0, 32'h0, 32'h0, rd, st, cg);
        check("tx_read_zero", rd, 32'h0);
        obi("t2b", 1'b1, 32'h1C, 32'h77, rd, st, cg);
        check("unmapped_wr_rdata", rd, 32'h0);
        obi("t2b", 1'b0, 32'hC, 32'h0, rd, st, cg);
        check("unmapped_wr_dropped", rd, 32'h0);

        // ---- 3. MISO pattern, divider 2 ----
        run_xfer("t3", 2, 32'h0000_0081, 1'b0, 32'h0000_003C);

        // ---- 4. TX write while busy stalls ----
        loop_en = 1'b1;
        a = 32'h0000_0096; b = 32'h0000_00C3;
        obi("t4", 1'b1, 32'hC, 32'd1, rd, st, cg);
        obi("t4", 1'b1, 32'h0, a, rd, st, cg);
        early_rv = 0;
        obi("t4", 1'b1, 32'h0, b, rd, st, cg);
        check("t4_stall_cycles", 32'(st), 32'(17 * 2 - 1));
        check("t4_cs_at_gnt", 32'(cg), 32'd1);
        check("t4_no_early_rvalid", 32'(early_rv), 32'd0);
        wait_done("t4");
        check("t4_rises", 32'(rises), 32'd8);
        check("t4_mosi", cap, b);
        obi("t4", 1'b0, 32'h4, 32'h0, rd, st, cg);
        check("t4_rx", rd, b);
        $display("[TB] t4 stalled write stall=%0d", st);

        // ---- 5. back-to-back reads ----
        obi_req_i = 1'b1; obi_we_i = 1'b0; obi_addr_i = 32'h8;
        @(negedge clk);
        check("t5_gnt0", 32'(obi_gnt_o), 32'd1);
        @(posedge clk); #1 obi_addr_i = 32'h4;
        @(negedge clk);
        check("t5_gnt1", 32'(obi_gnt_o), 32'd1);
        check("t5_rvalid0", 32'(obi_rvalid_o), 32'd1);
        check("t5_status", obi_rdata_o, 32'h0);
        @(posedge clk); #1 obi_addr_i = 32'h20;
        @(negedge clk);
        check("t5_gnt2", 32'(obi_gnt_o), 32'd1);
        check("t5_rvalid1", 32'(obi_rvalid_o), 32'd1);
        check("t5_rx", obi_rdata_o, b);
        @(posedge clk); #1 obi_req_i = 1'b0;
        @(negedge clk);
        check("t5_rvalid2", 32'(obi_rvalid_o), 32'd1);
        check("t5_unmapped", obi_rdata_o, 32'h0);
        @(posedge clk); #1;
        $display("[TB] t5 back-to-back reads done");

        // ---- 6. async reset mid-transfer ----
        loop_en = 1'b1;
        obi("t6", 1'b1, 32'hC, 32'd2, rd, st, cg);
        obi("t6", 1'b1, 32'h0, 32'h5A, rd, st, cg);
        n = 0;
        while (rises < 4 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check("t6_reached_bit4", 32'(rises), 32'd4);
        #1 rstn_i = 1'b0;
        #1;
        check("t6_cs_async", 32'(spi_cs_no), 32'd1);
        check("t6_sclk_async", 32'(spi_sclk_o), 32'd0);
        @(negedge clk); #2 rstn_i = 1'b1;
        @(posedge clk); #1;
        obi("t6", 1'b0, 32'h4, 32'h0, rd, st, cg);
        check("t6_rx_cleared", rd, 32'h0);
        obi("t6", 1'b0, 32'h8, 32'h0, rd, st, cg);
        check("t6_status", rd, 32'h0);
        $display("[TB] t6 reset mid-transfer");
        run_xfer("t6x", 4, 32'h0000_00FF, 1'b1, 32'h0);

        // ---- randomized transfers ----
        for (int i = 0; i < 6; i++) begin
            run_xfer($sformatf("rnd%0d", i), int'($urandom_range(0, 3)), $urandom,
                     1'($urandom_range(0, 1)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
